// File: rtl/udp_pkg.sv
// Shared definitions for the UDP payload stages: widths, framer state
// encoding and tkeep helper functions.
package udp_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = LEN_W + 1;
  localparam int KCNT_W = $clog2(KEEP_W + 1);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_t;

  // Number of valid bytes in a beat.
  function automatic logic [KCNT_W-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    logic [KCNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      n = n + KCNT_W'(keep[k]);
    end
    return n;
  endfunction

  // True when keep is of the form 0..01..1 (ones packed from bit 0).
  // An all-zero keep also satisfies this; callers reject it separately.
  function automatic logic keep_contiguous(input logic [KEEP_W-1:0] keep);
    logic [KEEP_W-1:0] plus_one;
    plus_one = keep + KEEP_W'(1);
    return (keep & plus_one) == '0;
  endfunction

endpackage

// File: rtl/udp_payload_framer_keep_decode.sv
// Combinational tkeep decode: byte count, contiguity flag and a
// per-bit data mask that zeroes disabled bytes.
module keep_decode
  import udp_pkg::*;
(
  input  logic [KEEP_W-1:0] keep,
  output logic [KCNT_W-1:0] count,
  output logic              contiguous,
  output logic [DATA_W-1:0] byte_mask
);

  // Expand each keep bit over its byte and evaluate the shared helpers.
  always_comb begin
    byte_mask  = '0;
    count      = keep_popcount(keep);
    contiguous = keep_contiguous(keep);
    for (int k = 0; k < KEEP_W; k++) begin
      byte_mask[8*k +: 8] = {8{keep[k]}};
    end
  end

endmodule

// File: rtl/udp_payload_framer.sv
// Passive AXI-Stream tap that turns accepted payload beats into
// checksum-ready big-endian words with sop/eop framing, and reports the
// payload length and framing errors with each end of packet.
//
// state       | meaning
// ------------+---------------------------------------------
// ST_IDLE     | waiting for the first beat of a frame
// ST_IN_FRAME | first beat seen, waiting for the tlast beat
module udp_payload_framer
  import udp_pkg::*;
#(
  parameter int MAX_BYTES = 8972
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tready,
  output logic [DATA_W-1:0] udp_data,
  output logic              udp_data_valid,
  output logic              sop,
  output logic              eop,
  output logic [LEN_W-1:0]  payload_len,
  output logic              len_valid,
  output logic              frame_err
);

  frame_state_t      state, state_nxt;
  logic [CNT_W-1:0]  len_cnt, len_nxt;
  logic              err_flag, err_nxt;

  logic              beat;
  logic              sop_nxt;
  logic [KCNT_W-1:0] keep_cnt;
  logic              keep_contig;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] swapped;
  logic [CNT_W-1:0]  len_base;
  logic [CNT_W-1:0]  len_sum;
  logic [LEN_W-1:0]  len_sat;
  logic              beat_err;
  logic              len_over;

  keep_decode u_keep_decode (
    .keep       (s_axis_tkeep),
    .count      (keep_cnt),
    .contiguous (keep_contig),
    .byte_mask  (byte_mask)
  );

  assign beat   = s_axis_tvalid & s_axis_tready;
  assign masked = s_axis_tdata & byte_mask;

  // Reverse byte order so each 16-bit lane is a network-order word.
  always_comb begin
    swapped = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      swapped[DATA_W-1-8*k -: 8] = masked[8*k +: 8];
    end
  end

  // Next-state, length accumulation and per-frame error tracking.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    err_nxt   = err_flag;
    sop_nxt   = 1'b0;

    // The sop beat restarts length and error regardless of history.
    len_base = (state == ST_IDLE) ? '0 : len_cnt;
    // Once past 16 bits the count freezes: the output is saturated and the
    // frame is already over any legal maximum, so no wrap can occur.
    len_sum  = len_base[CNT_W-1] ? len_base : len_base + CNT_W'(keep_cnt);
    len_sat  = len_sum[CNT_W-1] ? '1 : len_sum[LEN_W-1:0];
    len_over = len_sum > CNT_W'(MAX_BYTES);
    beat_err = s_axis_tlast ? (!keep_contig || (s_axis_tkeep == '0))
                            : (s_axis_tkeep != '1);

    if (beat) begin
      sop_nxt   = (state == ST_IDLE);
      len_nxt   = len_sum;
      err_nxt   = ((state == ST_IDLE) ? 1'b0 : err_flag) | beat_err | len_over;
      state_nxt = s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
    end
  end

  // Frame state, running length and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_cnt  <= len_nxt;
      err_flag <= err_nxt;
    end
  end

  // Output registers: one cycle behind acceptance; data holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      udp_data       <= '0;
      udp_data_valid <= 1'b0;
      sop            <= 1'b0;
      eop            <= 1'b0;
      len_valid      <= 1'b0;
      payload_len    <= '0;
      frame_err      <= 1'b0;
    end else begin
      udp_data_valid <= beat;
      sop            <= sop_nxt;
      eop            <= beat & s_axis_tlast;
      len_valid      <= beat & s_axis_tlast;
      if (beat) begin
        udp_data <= swapped;
      end
      if (beat && s_axis_tlast) begin
        payload_len <= len_sat;
        frame_err   <= err_nxt;
      end
    end
  end

endmodule
